pcileech_ac701_sysctl: RTL and testbench

//  System control stage between clk_wiz and the com/fifo/pcie cores on AC701. Sequences the

---
 rtl/pcileech_ac701_sysctl_pkg.sv | 23 ++
 rtl/pcileech_sysctl_debounce.sv | 66 ++++++
 rtl/pcileech_ac701_sysctl.sv | 189 ++++++++++++++++++
 tb/tb_pcileech_ac701_sysctl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_ac701_sysctl_pkg.sv
// -----------------------------------------------------------------------------
// pcileech_ac701_sysctl_pkg
// Shared types and helpers for the AC701 system-control slice.
//   sysctl_state_t : reset sequencer states
//   NUM_ACT_CH     : number of stretched activity LED channels (com, pcie)
//   cnt_width()    : counter width able to hold values 0..n-1 (minimum 1 bit)
// -----------------------------------------------------------------------------
package pcileech_ac701_sysctl_pkg;

  typedef enum logic [1:0] {
    S_POR   = 2'd0,
    S_RUN   = 2'd1,
    S_BTN   = 2'd2,
    S_PERST = 2'd3
  } sysctl_state_t;

  localparam int unsigned NUM_ACT_CH = 2;

  function automatic int cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcileech_sysctl_debounce.sv
// -----------------------------------------------------------------------------
// pcileech_sysctl_debounce
// Two-flop synchroniser followed by a consecutive-mismatch debounce counter.
// The output flips once the synchronised input has disagreed with it for
// CYCLES consecutive clocks (raw -> dout latency 2 + CYCLES). Any agreement
// clears the counter, so glitches shorter than CYCLES never reach dout.
// With CYCLES <= 1 the block degenerates to a plain 2-flop synchroniser.
// Ports:
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset (output resets to 0)
//   din   in  1  raw asynchronous input
//   dout  out 1  synchronised / debounced level
// -----------------------------------------------------------------------------
module pcileech_sysctl_debounce
  import pcileech_ac701_sysctl_pkg::*;
#(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
    end
  end

  generate
    if (CYCLES <= 1) begin : g_sync_only
      assign dout = r_s2;
    end else begin : g_debounce
      localparam int CW = cnt_width(CYCLES);
      localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

      logic [CW-1:0] r_cnt;
      logic          r_dout;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt  <= '0;
          r_dout <= 1'b0;
        end else if (r_s2 == r_dout) begin
          r_cnt <= '0;
        end else if (r_cnt == LAST) begin
          r_dout <= r_s2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign dout = r_dout;
    end
  endgenerate

endmodule

// File: rtl/pcileech_ac701_sysctl.sv
// -----------------------------------------------------------------------------
// pcileech_ac701_sysctl
// System control stage between clk_wiz and the com/fifo/pcie cores on AC701:
// power-on reset sequencing, button debounce, 64-bit tick counter and LEDs.
// The rst output is the only reset used by the downstream cores.
// Optional build macro: PCILEECH_SYSCTL_PERST_RST_EN adds pcie_perst_n, which
// (synchronised) forces the downstream reset and replays the POR on release.
// Ports:
//   clk           in   1  100 MHz system clock
//   rst_n         in   1  asynchronous active-low reset (clk_wiz locked)
//   btn_north     in   1  raw button, user reset request
//   btn_south     in   1  raw button, LED invert
//   act_com       in   1  1-cycle activity strobe from com
//   act_pcie      in   1  1-cycle activity strobe from pcie
//   pcie_perst_n  in   1  (macro builds only) PCIe PERST#, asynchronous
//   rst           out  1  registered active-high reset to com/fifo/pcie
//   ft601_rst_n   out  1  FT601 reset pad, always ~rst
//   tickcount64   out 64  free-running cycle counter
//   btn_south_db  out  1  debounced btn_south
//   led           out  3  [0] heartbeat, [1] com activity, [2] pcie activity
// -----------------------------------------------------------------------------
module pcileech_ac701_sysctl
  import pcileech_ac701_sysctl_pkg::*;
#(
  parameter int unsigned PARAM_POR_CYCLES      = 64,
  parameter int unsigned PARAM_DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned PARAM_STRETCH_CYCLES  = 5000000,
  parameter int unsigned PARAM_HEARTBEAT_BIT   = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_north,
  input  logic        btn_south,
  input  logic        act_com,
  input  logic        act_pcie,
`ifdef PCILEECH_SYSCTL_PERST_RST_EN
  input  logic        pcie_perst_n,
`endif
  output logic        rst,
  output logic        ft601_rst_n,
  output logic [63:0] tickcount64,
  output logic        btn_south_db,
  output logic [2:0]  led
);

  localparam int POR_W = cnt_width(PARAM_POR_CYCLES);
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(PARAM_POR_CYCLES - 1);
  localparam int ST_W = cnt_width(PARAM_STRETCH_CYCLES);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(PARAM_STRETCH_CYCLES - 1);

  logic w_north_db;
  logic w_south_db;

  pcileech_sysctl_debounce #(.CYCLES(PARAM_DEBOUNCE_CYCLES)) u_db_north (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (btn_north),
    .dout (w_north_db)
  );

  pcileech_sysctl_debounce #(.CYCLES(PARAM_DEBOUNCE_CYCLES)) u_db_south (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (btn_south),
    .dout (w_south_db)
  );

`ifdef PCILEECH_SYSCTL_PERST_RST_EN
  logic w_perst_sync;

  pcileech_sysctl_debounce #(.CYCLES(1)) u_sync_perst (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (pcie_perst_n),
    .dout (w_perst_sync)
  );
`endif

  // Reset sequencer
  sysctl_state_t    r_state;
  logic [POR_W-1:0] r_por_cnt;
  logic             r_rst;
  logic             r_north_prev;
  logic             w_north_rise;

  // The previous-value register tracks north in every state, so a press that
  // is already debounced when S_RUN is entered never counts as a new edge.
  assign w_north_rise = w_north_db & ~r_north_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_POR;
      r_por_cnt    <= '0;
      r_rst        <= 1'b1;
      r_north_prev <= 1'b0;
    end else begin
      r_north_prev <= w_north_db;
      case (r_state)
        S_POR: begin
          if (r_por_cnt == POR_LAST) begin
            r_state   <= S_RUN;
            r_rst     <= 1'b0;
            r_por_cnt <= '0;
          end else begin
            r_por_cnt <= r_por_cnt + 1'b1;
          end
        end
        S_RUN: begin
`ifdef PCILEECH_SYSCTL_PERST_RST_EN
          if (!w_perst_sync) begin
            r_state <= S_PERST;
            r_rst   <= 1'b1;
          end else
`endif
          if (w_north_rise) begin
            r_state <= S_BTN;
            r_rst   <= 1'b1;
          end
        end
        S_BTN: begin
          if (!w_north_db) begin
            r_state   <= S_POR;
            r_por_cnt <= '0;
          end
        end
`ifdef PCILEECH_SYSCTL_PERST_RST_EN
        S_PERST: begin
          if (w_perst_sync) begin
            r_state   <= S_POR;
            r_por_cnt <= '0;
          end
        end
`endif
        default: begin
          r_state   <= S_POR;
          r_por_cnt <= '0;
          r_rst     <= 1'b1;
        end
      endcase
    end
  end

  // Tick counter: never touched by the button/PERST reset paths
  logic [63:0] r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick <= '0;
    else        r_tick <= r_tick + 64'd1;
  end

  // Activity stretchers: led rises the cycle after a strobe and stays on for
  // STRETCH cycles after the most recent one.
  logic [NUM_ACT_CH-1:0] w_act;
  logic [NUM_ACT_CH-1:0] w_led_act;

  assign w_act = {act_pcie, act_com};

  generate
    for (genvar g = 0; g < NUM_ACT_CH; g++) begin : g_stretch
      logic [ST_W-1:0] r_cnt;
      logic            r_on;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
          r_on  <= 1'b0;
        end else if (r_rst) begin
          r_cnt <= '0;
          r_on  <= 1'b0;
        end else begin
          r_on <= w_act[g] | (r_cnt != '0);
          if (w_act[g])            r_cnt <= ST_LOAD;
          else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
        end
      end

      assign w_led_act[g] = r_on;
    end
  endgenerate

  assign rst          = r_rst;
  assign ft601_rst_n  = ~r_rst;
  assign tickcount64  = r_tick;
  assign btn_south_db = w_south_db;
  assign led = {w_led_act[1] ^ w_south_db,
                w_led_act[0] ^ w_south_db,
                r_tick[PARAM_HEARTBEAT_BIT] ^ w_south_db ^ w_north_db};

endmodule

// File: tb/tb_pcileech_ac701_sysctl.sv
// -----------------------------------------------------------------------------
// tb_pcileech_ac701_sysctl
// Bench for pcileech_ac701_sysctl with POR=8, DEBOUNCE=4, STRETCH=10,
// HEARTBEAT_BIT=3. Inputs change 1 time unit after a rising edge; outputs are
// compared at that same point, i.e. they show the state left by that edge.
// -----------------------------------------------------------------------------
module tb_pcileech_ac701_sysctl;

  localparam int POR = 8;
  localparam int DEB = 4;
  localparam int STR = 10;
  localparam int HB  = 3;

  logic        clk;
  logic        rst_n;
  logic        btn_north;
  logic        btn_south;
  logic        act_com;
  logic        act_pcie;
  logic        rst;
  logic        ft601_rst_n;
  logic [63:0] tickcount64;
  logic        btn_south_db;
  logic [2:0]  led;
`ifdef PCILEECH_SYSCTL_PERST_RST_EN
  logic        pcie_perst_n;
`endif

  pcileech_ac701_sysctl #(
    .PARAM_POR_CYCLES     (POR),
    .PARAM_DEBOUNCE_CYCLES(DEB),
    .PARAM_STRETCH_CYCLES (STR),
    .PARAM_HEARTBEAT_BIT  (HB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_north   (btn_north),
    .btn_south   (btn_south),
    .act_com     (act_com),
    .act_pcie    (act_pcie),
`ifdef PCILEECH_SYSCTL_PERST_RST_EN
    .pcie_perst_n(pcie_perst_n),
`endif
    .rst         (rst),
    .ft601_rst_n (ft601_rst_n),
    .tickcount64 (tickcount64),
    .btn_south_db(btn_south_db),
    .led         (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;   // edges since rst_n released: the expected tickcount

  typedef struct {
    int mode;      // 0: btn_south pulse of 'arg' cycles, 1: two act_com strobes 'arg' apart
    int arg;
    int exp_high;  // cycles the observed output is high
  } vec_t;

  vec_t vecs[12];

  // Reference-model state for the random phase
  bit s_raw[0:1023];
  bit m_db;
  int last_acc[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) cyc++;
  endtask

  task automatic idle(input int n);
    btn_north = 1'b0;
    btn_south = 1'b0;
    act_com   = 1'b0;
    act_pcie  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input bit north_held);
    btn_north = north_held;
    btn_south = 1'b0;
    act_com   = 1'b0;
    act_pcie  = 1'b0;
    rst_n     = 1'b0;
    for (int i = 0; i < 3; i++) step();
    cyc   = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int hold;
    bit all_flip;
    bit v;
    bit exp_act[2];
    logic [63:0] tk;

    // Debounce pulse lengths: shorter than DEB vanish, otherwise the
    // debounced level is a delayed copy of the same width.
    vecs[0]  = '{0, 1, 0};
    vecs[1]  = '{0, 2, 0};
    vecs[2]  = '{0, 3, 0};
    vecs[3]  = '{0, 4, 4};
    vecs[4]  = '{0, 5, 5};
    vecs[5]  = '{0, 9, 9};
    // Two strobes g apart: each lights the LED for STR cycles, overlapping
    // windows merge, so high time = min(g, STR) + STR.
    vecs[6]  = '{1, 1, 11};
    vecs[7]  = '{1, 3, 13};
    vecs[8]  = '{1, 9, 19};
    vecs[9]  = '{1, 10, 20};
    vecs[10] = '{1, 11, 20};
    vecs[11] = '{1, 14, 20};

`ifdef PCILEECH_SYSCTL_PERST_RST_EN
    pcie_perst_n = 1'b1;
`endif
    btn_north = 1'b0;
    btn_south = 1'b0;
    act_com   = 1'b0;
    act_pcie  = 1'b0;
    rst_n     = 1'b0;

    // 1: reset state, then POR of exactly POR edges
    for (int i = 0; i < 5; i++) step();
    check("rst_in_reset", rst, 1);
    check("ft601_in_reset", ft601_rst_n, 0);
    check("tick_in_reset", tickcount64, 0);
    check("led_in_reset", led, 0);
    check("sdb_in_reset", btn_south_db, 0);
    cyc   = 0;
    rst_n = 1'b1;
    for (int e = 1; e <= POR; e++) begin
      step();
      check("por_rst", rst, (e < POR) ? 1 : 0);
      check("por_ft601", ft601_rst_n, (e < POR) ? 0 : 1);
    end
    check("por_tick", tickcount64, 64'(cyc));

    // 2: short north glitch ignored; long press resets
    btn_north = 1'b1;
    for (int i = 0; i < 3; i++) step();
    btn_north = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check("north_glitch_rst", rst, 0);
    end
    btn_north = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      // debounced rises at edge 2+DEB, registered FSM raises rst one edge later
      check("north_press_rst", rst, (e >= DEB + 3) ? 1 : 0);
    end
    btn_north = 1'b0;
    for (int e = 21; e <= 40; e++) begin
      step();
      // debounced falls at edge 20+2+DEB, then S_POR from the next edge for POR edges
      check("north_release_rst", rst, (e < 20 + DEB + 3 + POR) ? 1 : 0);
    end

    // 3: pcie stretch, single then retriggered
    act_pcie = 1'b1;
    step();
    act_pcie = 1'b0;
    check("pcie_led_rise", led[2], 1);
    for (int e = 1; e <= 12; e++) begin
      step();
      check("pcie_led_single", led[2], (e <= STR - 1) ? 1 : 0);
    end
    for (int e = 0; e <= 22; e++) begin
      act_pcie = (e == 0 || e == 9);
      step();
      act_pcie = 1'b0;
      check("pcie_led_retrig", led[2], (e <= 9 + STR - 1) ? 1 : 0);
    end

    // 4: south held inverts the LEDs
    btn_south = 1'b1;
    for (int e = 1; e <= DEB + 2; e++) begin
      step();
      check("south_db_rise", btn_south_db, (e >= DEB + 2) ? 1 : 0);
    end
    tk = 64'(cyc);
    check("south_led1_inv", led[1], 1);
    check("south_led2_inv", led[2], 1);
    check("south_led0_inv", led[0], tk[HB] ^ 1'b1);
    btn_south = 1'b0;
    for (int e = 1; e <= DEB + 2; e++) begin
      step();
      check("south_db_fall", btn_south_db, (e < DEB + 2) ? 1 : 0);
    end

    // 5: asynchronous reset in the middle of a stretch with south debounced high
    btn_south = 1'b1;
    for (int i = 0; i < 8; i++) step();
    act_com = 1'b1;
    step();
    act_com = 1'b0;
    step();
    step();
    btn_south = 1'b0;
    rst_n = 1'b0;
    #2;
    check("async_rst", rst, 1);
    check("async_ft601", ft601_rst_n, 0);
    check("async_led", led, 0);
    check("async_tick", tickcount64, 0);
    check("async_sdb", btn_south_db, 0);
    step();
    step();
    cyc   = 0;
    rst_n = 1'b1;
    for (int e = 1; e <= POR; e++) begin
      step();
      check("replay_por_rst", rst, (e < POR) ? 1 : 0);
    end
    check("replay_led", led[2:1], 0);
    check("replay_tick", tickcount64, 64'(POR));

    // north held through POR does not trigger a user reset
    do_reset(1'b1);
    for (int e = 1; e <= 30; e++) begin
      step();
      check("north_held_por_rst", rst, (e < POR) ? 1 : 0);
    end
    btn_north = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("north_held_release_rst", rst, 0);
    end

`ifdef PCILEECH_SYSCTL_PERST_RST_EN
    // PERST# low for 4 cycles: rst within 3 edges, then replayed POR
    pcie_perst_n = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      if (e == 5) pcie_perst_n = 1'b1;
      step();
      check("perst_rst", rst, (e >= 3 && e < 7 + POR) ? 1 : 0);
    end
`endif

    // Table-driven vectors
    foreach (vecs[i]) begin
      idle(20);
      cnt = 0;
      if (vecs[i].mode == 0) begin
        for (int e = 1; e <= vecs[i].arg + 20; e++) begin
          btn_south = (e <= vecs[i].arg);
          step();
          cnt += int'(btn_south_db);
        end
        btn_south = 1'b0;
        check($sformatf("vec%0d_south_pulse%0d", i, vecs[i].arg), 64'(cnt), 64'(vecs[i].exp_high));
      end else begin
        for (int e = 0; e < 30; e++) begin
          act_com = (e == 0 || e == vecs[i].arg);
          step();
          act_com = 1'b0;
          cnt += int'(led[1]);
        end
        check($sformatf("vec%0d_com_gap%0d", i, vecs[i].arg), 64'(cnt), 64'(vecs[i].exp_high));
      end
    end

    // Random south/activity traffic against a window/last-strobe model
    do_reset(1'b0);
    foreach (s_raw[i]) s_raw[i] = 1'b0;
    m_db        = 1'b0;
    last_acc[0] = -1000;
    last_acc[1] = -1000;
    hold        = 0;
    for (int k = 1; k <= 600; k++) begin
      if (hold == 0) begin
        btn_south = 1'($urandom_range(0, 1));
        hold      = $urandom_range(1, 8);
      end
      hold--;
      act_com  = ($urandom_range(0, 6) == 0);
      act_pcie = ($urandom_range(0, 6) == 0);
      s_raw[k] = btn_south;
      // strobes count only once the POR has finished (rst low before this edge)
      if (k > POR && act_com)  last_acc[0] = k;
      if (k > POR && act_pcie) last_acc[1] = k;
      step();
      // debounced flips when the DEB synchronised samples (raw delayed by 2)
      // feeding this edge all disagree with it
      all_flip = 1'b1;
      for (int i = 0; i < DEB; i++) begin
        v = (k - 2 - i >= 1) ? s_raw[k - 2 - i] : 1'b0;
        if (v == m_db) all_flip = 1'b0;
      end
      if (all_flip) m_db = ~m_db;
      for (int c = 0; c < 2; c++) exp_act[c] = ((k - last_acc[c]) <= STR - 1);
      tk = 64'(k);
      check("rnd_rst", rst, (k < POR) ? 1 : 0);
      check("rnd_tick", tickcount64, tk);
      check("rnd_sdb", btn_south_db, m_db);
      check("rnd_led", led, {exp_act[1] ^ m_db, exp_act[0] ^ m_db, tk[HB] ^ m_db});
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
